// File: rtl/demux16_buf_pkg.sv
// demux16_buf_pkg
//   Shared types for the 16-way write-side demux: the LC-3b word, the slot
//   select, the 16-entry word array and the occupancy count, plus a popcount
//   helper used for occupancy bookkeeping.
package demux16_buf_pkg;

   localparam int unsigned NUM_SLOTS = 16;

   typedef logic [15:0]     lc3b_word;
   typedef logic [3:0]      lc3b_slot_sel;
   typedef lc3b_word [15:0] lc3b_word_array16;
   typedef logic [4:0]      lc3b_occ;

   function automatic lc3b_occ popcount16(input logic [15:0] v);
      lc3b_occ cnt;
      cnt = '0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
         cnt = cnt + lc3b_occ'(v[i]);
      end
      return cnt;
   endfunction

endpackage

// File: rtl/demux16_buf_if.sv
// demux16_buf_if
//   Producer-to-demux and demux-to-consumer signals for demux16_buf.
//   in_valid/in_ready/in_sel/in_data : single producer push handshake
//   out_valid/out_data/out_ack       : 16 independent slot handshakes
//   master : producer/consumer side (testbench or datapath)
//   slave  : demux16_buf
interface demux16_buf_if;
   import demux16_buf_pkg::*;

   logic             in_valid;
   logic             in_ready;
   lc3b_slot_sel     in_sel;
   lc3b_word         in_data;
   logic [15:0]      out_valid;
   lc3b_word_array16 out_data;
   logic [15:0]      out_ack;

   modport master (
      output in_valid, in_sel, in_data, out_ack,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_sel, in_data, out_ack,
      output in_ready, out_valid, out_data
   );

endinterface

// File: rtl/demux16_slot.sv
// demux16_slot
//   One-entry holding register with a valid/ack handshake.
//   clk, rst_n : clock, asynchronous active-low reset
//   push_en    : write wdata this edge (already qualified by the top level)
//   ack        : consumer takes the word this edge
//   wdata      : word to store
//   ready      : slot can accept a push this cycle
//   pop        : a pop happens at this edge (ack while valid)
//   valid/data : slot contents
module demux16_slot
   import demux16_buf_pkg::*;
#(
   parameter bit ALLOW_BYPASS = 1'b1,
   parameter bit CLEAR_ON_POP = 1'b1
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     push_en,
   input  logic     ack,
   input  lc3b_word wdata,
   output logic     ready,
   output logic     pop,
   output logic     valid,
   output lc3b_word data
);

   assign pop   = ack & valid;
   // A full slot being drained this edge may be refilled in the same edge.
   assign ready = ~valid | (ALLOW_BYPASS & ack);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         data  <= '0;
      end else if (push_en) begin
         valid <= 1'b1;
         data  <= wdata;
      end else if (pop) begin
         valid <= 1'b0;
         if (CLEAR_ON_POP) begin
            data <= '0;
         end
      end
   end

endmodule

// File: rtl/demux16_buf.sv
// demux16_buf
//   Delivers one LC-3b word per transfer to one of 16 holding slots, each
//   drained independently by its own consumer.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : push handshake and 16 slot handshakes (slave modport)
//   occupancy  : number of full slots, 0..16
//   ack_err    : sticky, set when a consumer acks an empty slot
module demux16_buf
   import demux16_buf_pkg::*;
#(
   parameter bit ALLOW_BYPASS = 1'b1,
   parameter bit CLEAR_ON_POP = 1'b1
) (
   input  logic           clk,
   input  logic           rst_n,
   demux16_buf_if.slave   bus,
   output lc3b_occ        occupancy,
   output logic           ack_err
);

   logic [15:0]      wr_onehot;
   logic [15:0]      slot_ready;
   logic [15:0]      slot_pop;
   logic [15:0]      slot_valid;
   lc3b_word_array16 slot_data;
   logic             push;

   always_comb begin
      wr_onehot = 16'h0001 << bus.in_sel;
   end

   assign bus.in_ready  = slot_ready[bus.in_sel];
   assign push          = bus.in_valid & bus.in_ready;
   assign bus.out_valid = slot_valid;
   assign bus.out_data  = slot_data;

   for (genvar k = 0; k < 16; k++) begin : g_slot
      demux16_slot #(
         .ALLOW_BYPASS (ALLOW_BYPASS),
         .CLEAR_ON_POP (CLEAR_ON_POP)
      ) u_slot (
         .clk     (clk),
         .rst_n   (rst_n),
         .push_en (push & wr_onehot[k]),
         .ack     (bus.out_ack[k]),
         .wdata   (bus.in_data),
         .ready   (slot_ready[k]),
         .pop     (slot_pop[k]),
         .valid   (slot_valid[k]),
         .data    (slot_data[k])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occupancy <= '0;
         ack_err   <= 1'b0;
      end else begin
         // A bypass refill counts as one pop plus one push, so the net is zero.
         occupancy <= occupancy + lc3b_occ'(push) - popcount16(slot_pop);
         if (|(bus.out_ack & ~slot_valid)) begin
            ack_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_demux16_buf.sv
// tb_demux16_buf
//   Directed and randomized checks of demux16_buf against a per-slot
//   behavioural model kept in arrays.
module tb_demux16_buf;
   import demux16_buf_pkg::*;

   localparam bit BYP = 1'b1;
   localparam bit CLR = 1'b1;

   logic         clk;
   logic         rst_n;
   logic         iv;
   logic [3:0]   sel;
   logic [15:0]  dat;
   logic [15:0]  ack;
   lc3b_occ      occupancy;
   logic         ack_err;

   int errors;
   int checks;

   logic     mv [16];
   lc3b_word md [16];
   logic     merr;

   demux16_buf_if bus ();

   assign bus.in_valid = iv;
   assign bus.in_sel   = sel;
   assign bus.in_data  = dat;
   assign bus.out_ack  = ack;

   demux16_buf #(
      .ALLOW_BYPASS (BYP),
      .CLEAR_ON_POP (CLR)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus.slave),
      .occupancy (occupancy),
      .ack_err   (ack_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic logic model_ready(input logic [3:0] s, input logic [15:0] a);
      return !mv[s] || (BYP && a[s]);
   endfunction

   function automatic logic [15:0] mvec();
      logic [15:0] v;
      for (int k = 0; k < 16; k++) v[k] = mv[k];
      return v;
   endfunction

   function automatic int mocc();
      int n;
      n = 0;
      for (int k = 0; k < 16; k++) if (mv[k]) n++;
      return n;
   endfunction

   task automatic model_clear();
      for (int k = 0; k < 16; k++) begin
         mv[k] = 1'b0;
         md[k] = 16'h0000;
      end
      merr = 1'b0;
   endtask

   task automatic model_edge();
      logic do_push;
      do_push = iv && model_ready(sel, ack);
      for (int k = 0; k < 16; k++) begin
         if (ack[k] && !mv[k]) merr = 1'b1;
         if (do_push && (k == int'(sel))) begin
            mv[k] = 1'b1;
            md[k] = dat;
         end else if (ack[k] && mv[k]) begin
            mv[k] = 1'b0;
            if (CLR) md[k] = 16'h0000;
         end
      end
   endtask

   // One rising edge with the currently driven inputs; returns at edge+1.
   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle();
      iv  = 1'b0;
      sel = 4'd0;
      dat = 16'h0000;
      ack = 16'h0000;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      // Put a word in slot 3, then drop reset while a push to slot 3 is offered.
      iv = 1'b1; sel = 4'd3; dat = 16'h7777; ack = 16'h0000;
      tick();
      dat = 16'h8888;
      @(negedge clk);
      rst_n = 1'b0;
      model_clear();
      #1;
      checks++;
      if (bus.out_valid !== 16'h0000) begin
         errors++;
         $display("FAIL reset_async_valid: got %h want %h", bus.out_valid, 16'h0000);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      idle();
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (bus.out_valid !== mvec()) begin
         errors++;
         $display("FAIL reset_valid: got %h want %h", bus.out_valid, mvec());
      end
      checks++;
      if (occupancy !== 5'd0) begin
         errors++;
         $display("FAIL reset_occ: got %0d want 0", occupancy);
      end
      checks++;
      if (ack_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_ack_err: got %b want 0", ack_err);
      end
      for (int k = 0; k < 16; k++) begin
         checks++;
         if (bus.out_data[k] !== 16'h0000) begin
            errors++;
            $display("FAIL reset_data[%0d]: got %h want 0000", k, bus.out_data[k]);
         end
      end
   endtask

   task automatic test_single_push();
      iv = 1'b1; sel = 4'd5; dat = 16'hBEEF; ack = 16'h0000;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL single_ready: got %b want 1", bus.in_ready);
      end
      tick();
      idle();
      checks++;
      if (bus.out_valid !== 16'h0020) begin
         errors++;
         $display("FAIL single_valid: got %h want 0020", bus.out_valid);
      end
      checks++;
      if (bus.out_data[5] !== 16'hBEEF) begin
         errors++;
         $display("FAIL single_data: got %h want BEEF", bus.out_data[5]);
      end
      checks++;
      if (occupancy !== 5'd1) begin
         errors++;
         $display("FAIL single_occ: got %0d want 1", occupancy);
      end
      ack = 16'h0020;
      tick();
      idle();
      checks++;
      if (bus.out_valid !== 16'h0000) begin
         errors++;
         $display("FAIL single_pop_valid: got %h want 0000", bus.out_valid);
      end
      checks++;
      if (bus.out_data[5] !== md[5]) begin
         errors++;
         $display("FAIL single_pop_data: got %h want %h", bus.out_data[5], md[5]);
      end
      checks++;
      if (occupancy !== 5'd0) begin
         errors++;
         $display("FAIL single_pop_occ: got %0d want 0", occupancy);
      end
   endtask

   task automatic test_backpressure();
      iv = 1'b1; sel = 4'd7; dat = 16'h0777; ack = 16'h0000;
      tick();
      dat = 16'h1234;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++;
         if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_ready cycle %0d: got %b want 0", c, bus.in_ready);
         end
         tick();
         checks++;
         if (bus.out_valid[7] !== 1'b1 || bus.out_data[7] !== md[7]) begin
            errors++;
            $display("FAIL bp_hold cycle %0d: got %b/%h want 1/%h",
                     c, bus.out_valid[7], bus.out_data[7], md[7]);
         end
      end
      ack = 16'h0080;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_bypass_ready: got %b want 1", bus.in_ready);
      end
      tick();
      idle();
      checks++;
      if (bus.out_valid[7] !== 1'b1 || bus.out_data[7] !== 16'h1234) begin
         errors++;
         $display("FAIL bp_bypass_data: got %b/%h want 1/1234",
                  bus.out_valid[7], bus.out_data[7]);
      end
      checks++;
      if (occupancy !== 5'(mocc())) begin
         errors++;
         $display("FAIL bp_occ: got %0d want %0d", occupancy, mocc());
      end
      ack = 16'h0080;
      tick();
      idle();
   endtask

   task automatic test_fill_all();
      for (int k = 0; k < 16; k++) begin
         iv = 1'b1; sel = 4'(k); dat = 16'h1000 + 16'(k); ack = 16'h0000;
         tick();
      end
      idle();
      checks++;
      if (occupancy !== 5'd16) begin
         errors++;
         $display("FAIL fill_occ: got %0d want 16", occupancy);
      end
      checks++;
      if (bus.out_valid !== 16'hFFFF) begin
         errors++;
         $display("FAIL fill_valid: got %h want FFFF", bus.out_valid);
      end
      for (int k = 0; k < 16; k++) begin
         sel = 4'(k);
         #1;
         checks++;
         if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_ready[%0d]: got %b want 0", k, bus.in_ready);
         end
         checks++;
         if (bus.out_data[k] !== md[k]) begin
            errors++;
            $display("FAIL fill_data[%0d]: got %h want %h", k, bus.out_data[k], md[k]);
         end
      end
      sel = 4'd0;
   endtask

   task automatic test_multi_pop();
      iv = 1'b1; sel = 4'd0; dat = 16'hABCD; ack = 16'hA5A5;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL mpop_ready: got %b want 1", bus.in_ready);
      end
      tick();
      idle();
      checks++;
      if (bus.out_valid !== 16'h5A5B) begin
         errors++;
         $display("FAIL mpop_valid: got %h want 5A5B", bus.out_valid);
      end
      checks++;
      if (occupancy !== 5'd9) begin
         errors++;
         $display("FAIL mpop_occ: got %0d want 9", occupancy);
      end
      for (int k = 0; k < 16; k++) begin
         checks++;
         if (bus.out_data[k] !== md[k]) begin
            errors++;
            $display("FAIL mpop_data[%0d]: got %h want %h", k, bus.out_data[k], md[k]);
         end
      end
      checks++;
      if (ack_err !== 1'b0) begin
         errors++;
         $display("FAIL mpop_ack_err: got %b want 0", ack_err);
      end
      ack = mvec();
      tick();
      idle();
   endtask

   task automatic test_spurious_ack();
      iv = 1'b1; sel = 4'd9; dat = 16'h5959; ack = 16'h0000;
      tick();
      idle();
      ack = 16'h0004;
      tick();
      idle();
      for (int c = 0; c < 3; c++) begin
         checks++;
         if (ack_err !== 1'b1) begin
            errors++;
            $display("FAIL spur_ack_err cycle %0d: got %b want 1", c, ack_err);
         end
         tick();
      end
      checks++;
      if (bus.out_valid !== 16'h0200 || bus.out_data[9] !== 16'h5959) begin
         errors++;
         $display("FAIL spur_slots: got %h/%h want 0200/5959", bus.out_valid, bus.out_data[9]);
      end
      checks++;
      if (occupancy !== 5'd1) begin
         errors++;
         $display("FAIL spur_occ: got %0d want 1", occupancy);
      end
      do_reset();
      checks++;
      if (ack_err !== 1'b0) begin
         errors++;
         $display("FAIL spur_clear: got %b want 0", ack_err);
      end
   endtask

   task automatic test_random();
      logic hold;
      hold = 1'b0;
      for (int c = 0; c < 300; c++) begin
         if (!hold) begin
            iv  = 1'($urandom_range(0, 2) != 0);
            sel = 4'($urandom_range(0, 15));
            dat = 16'($urandom);
         end
         ack = 16'($urandom) & 16'($urandom) & 16'($urandom);
         #1;
         checks++;
         if (bus.in_ready !== model_ready(sel, ack)) begin
            errors++;
            $display("FAIL rand_ready c%0d: got %b want %b", c, bus.in_ready, model_ready(sel, ack));
         end
         hold = iv && !model_ready(sel, ack);
         tick();
         checks++;
         if (bus.out_valid !== mvec()) begin
            errors++;
            $display("FAIL rand_valid c%0d: got %h want %h", c, bus.out_valid, mvec());
         end
         checks++;
         if (occupancy !== 5'(mocc())) begin
            errors++;
            $display("FAIL rand_occ c%0d: got %0d want %0d", c, occupancy, mocc());
         end
         checks++;
         if (ack_err !== merr) begin
            errors++;
            $display("FAIL rand_ack_err c%0d: got %b want %b", c, ack_err, merr);
         end
         for (int k = 0; k < 16; k++) begin
            checks++;
            if (bus.out_data[k] !== md[k]) begin
               errors++;
               $display("FAIL rand_data[%0d] c%0d: got %h want %h", k, c, bus.out_data[k], md[k]);
            end
         end
      end
      idle();
   endtask

   initial begin
      errors = 0;
      checks = 0;
      idle();
      model_clear();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      test_reset();
      test_single_push();
      test_backpressure();
      test_fill_all();
      test_multi_pop();
      test_spurious_ack();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
